t5_dwb_bridge: RTL and testbench

- Registered bridge between the CPU data port (dwb_*) and an external Wishbone-classic data bus.
- Sits directly downstream of the CPU data stage.
- Accepts one CPU request at a time, re-times it onto the external bus, and returns one single-cycle dwb_ack with read data.
- Converts slave error responses and unresponsive slaves (timeout) into a completed access, so the CPU never hangs. Latches a sticky bus-error flag and the faulting address.

---
 rtl/t5_dwb_bridge_pkg.sv | 25 ++
 rtl/t5_dwb_tmr.sv | 37 +++
 rtl/t5_dwb_bridge.sv | 118 +++++++++++
 tb/tb_t5_dwb_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/t5_dwb_bridge_pkg.sv
// ============================================================================
// Module  : t5_dwb_bridge_pkg
// Brief   : Shared state encodings and defaults for the dwb-to-Wishbone bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package t5_dwb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] C_ERRDAT_DEFAULT = 32'h0000_0000;

    // A 1-bit counter is the floor so TIMEOUT=2 still yields a legal vector.
    function automatic int tmr_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

`default_nettype wire

// File: rtl/t5_dwb_tmr.sv
// ============================================================================
// Module  : t5_dwb_tmr
// Brief   : Bus-cycle watchdog counter; o_expire marks the last allowed cycle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module t5_dwb_tmr
    import t5_dwb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW     = tmr_width(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/t5_dwb_bridge.sv
// ============================================================================
// Module  : t5_dwb_bridge
// Brief   : Registered CPU data port to Wishbone-classic bridge with timeout
//           and sticky bus-error capture.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module t5_dwb_bridge
    import t5_dwb_bridge_pkg::*;
#(
    parameter int                XLEN    = 32,
    parameter int                TIMEOUT = 64,
    parameter logic [XLEN-1:0]   ERRDAT  = XLEN'(C_ERRDAT_DEFAULT)
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [XLEN-3:0] dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    input  logic [3:0]      dwb_sel,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    output logic [XLEN-1:0] dwb_dti,
    output logic            dwb_ack,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [XLEN-3:0] wb_adr_o,
    output logic [3:0]      wb_sel_o,
    output logic [XLEN-1:0] wb_dat_o,
    input  logic [XLEN-1:0] wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    output logic            berr,
    output logic [XLEN-3:0] berr_adr,
    input  logic            berr_clr
);

    state_t r_state;
    state_t w_next;
    logic   w_busy;
    logic   w_expire;
    logic   w_finish;
    logic   w_fault;

    assign w_busy   = (r_state == ST_BUSY);
    assign w_finish = w_busy && (wb_ack_i || wb_err_i || w_expire);
    assign w_fault  = w_busy && !wb_ack_i && (wb_err_i || w_expire);

    t5_dwb_tmr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_clr    (r_state == ST_IDLE),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (dwb_stb) w_next = ST_BUSY;
            ST_BUSY: if (w_finish) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes so they drop on reset at once.
    assign wb_cyc_o = w_busy;
    assign wb_stb_o = w_busy;
    assign dwb_ack  = (r_state == ST_DONE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            dwb_dti  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && dwb_stb) begin
                wb_we_o  <= dwb_wre;
                wb_adr_o <= dwb_adr;
                wb_sel_o <= dwb_sel;
                wb_dat_o <= dwb_dto;
            end
            if (w_finish) begin
                dwb_dti <= wb_ack_i ? wb_dat_i : ERRDAT;
            end
        end
    end

    // A new fault outranks a concurrent clear and re-arms the address capture.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            berr     <= 1'b0;
            berr_adr <= '0;
        end else if (w_fault && (!berr || berr_clr)) begin
            berr     <= 1'b1;
            berr_adr <= wb_adr_o;
        end else if (berr_clr) begin
            berr     <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_t5_dwb_bridge.sv
// ============================================================================
// Module  : tb_t5_dwb_bridge
// Brief   : Directed scoreboard bench for t5_dwb_bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_t5_dwb_bridge;

    localparam int          TIMEOUT = 64;
    localparam logic [31:0] ERRDAT  = 32'h0000_0000;
    localparam int          R_ACK   = 0;
    localparam int          R_ERR   = 1;
    localparam int          R_NONE  = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_stb;
    logic        dwb_wre;
    logic [31:0] dwb_dti;
    logic        dwb_ack;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        berr;
    logic [29:0] berr_adr;
    logic        berr_clr;

    typedef struct {
        logic [31:0] dti;
        logic        berr;
        logic [29:0] badr;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_vec  = 0;
    int          n_miss = 0;
    int          acks   = 0;
    int          acks_exp = 0;
    logic        m_berr = 1'b0;
    logic [29:0] m_badr = '0;

    t5_dwb_bridge #(
        .XLEN    (32),
        .TIMEOUT (TIMEOUT),
        .ERRDAT  (ERRDAT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .dwb_adr  (dwb_adr),
        .dwb_dto  (dwb_dto),
        .dwb_sel  (dwb_sel),
        .dwb_stb  (dwb_stb),
        .dwb_wre  (dwb_wre),
        .dwb_dti  (dwb_dti),
        .dwb_ack  (dwb_ack),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .berr     (berr),
        .berr_adr (berr_adr),
        .berr_clr (berr_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drives one CPU access and plays the slave; resp selects ack, err or silence.
    task automatic access(input logic [29:0] adr, input logic [31:0] dto, input logic [3:0] sel,
                          input logic wre, input int waits, input int resp,
                          input logic [31:0] rdat, input logic clr);
        exp_t e;
        int   cnt;
        dwb_adr = adr; dwb_dto = dto; dwb_sel = sel; dwb_wre = wre; dwb_stb = 1'b1;
        tick();
        chk("stb_first", {wb_cyc_o, wb_stb_o}, 2'b11);
        chk("req_fields", {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, {wre, adr, sel, dto});
        e.dti = (resp == R_ACK) ? rdat : ERRDAT;
        if ((resp != R_ACK) && (!m_berr || clr)) begin
            m_berr = 1'b1;
            m_badr = adr;
        end else if (clr) begin
            m_berr = 1'b0;
        end
        e.berr = m_berr;
        e.badr = m_badr;
        q.push_back(e);
        acks_exp++;
        if (resp == R_NONE) begin
            cnt = 0;
            while (wb_stb_o === 1'b1 && cnt < TIMEOUT + 10) begin
                cnt++;
                tick();
            end
            chk("timeout_len", cnt, TIMEOUT);
        end else begin
            for (int i = 0; i < waits; i++) begin
                tick();
                chk("hold", {wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o},
                    {1'b1, wre, adr, sel, dto});
            end
            if (resp == R_ACK) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rdat;
            end else begin
                wb_err_i = 1'b1;
            end
            berr_clr = clr;
            tick();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            berr_clr = 1'b0;
            wb_dat_i = $urandom;
        end
        chk("ack_pulse", {dwb_ack, wb_cyc_o}, 2'b10);
        dwb_stb = 1'b0;
        tick();
        chk("ack_single", dwb_ack, 1'b0);
        chk("dti_hold", dwb_dti, e.dti);
    endtask

    always @(negedge sys_clk) begin
        if (dwb_ack === 1'b1) begin
            acks++;
            chk("ack_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("dti", dwb_dti, mon_e.dti);
                chk("berr", berr, mon_e.berr);
                chk("berr_adr", berr_adr, mon_e.badr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; dwb_adr = '0; dwb_dto = '0; dwb_sel = '0; dwb_stb = 1'b0;
        dwb_wre = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; berr_clr = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            {dwb_dti, dwb_ack, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, berr, berr_adr},
            133'd0);
        sys_rst = 1'b0;
        tick();

        access(30'h40, 32'h0, 4'hF, 1'b0, 0, R_ACK, 32'hCAFE_F00D, 1'b0);
        access(30'h21, 32'h1234_5678, 4'h3, 1'b1, 3, R_ACK, 32'hDEAD_BEEF, 1'b0);
        chk("berr_after_write", berr, 1'b0);
        access(30'h3FF, 32'h0, 4'hF, 1'b0, 1, R_ERR, 32'h0, 1'b0);
        access(30'h100, 32'h0, 4'hF, 1'b0, 0, R_ERR, 32'h0, 1'b0);
        access(30'h2, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0, 1'b0);
        access(30'h55, 32'hAAAA_5555, 4'hC, 1'b1, 2, R_ERR, 32'h0, 1'b1);
        chk("berr_adr_clr_win", {berr, berr_adr}, {1'b1, 30'h55});

        berr_clr = 1'b1;
        tick();
        berr_clr = 1'b0;
        m_berr = 1'b0;
        chk("berr_cleared", berr, 1'b0);

        access(30'h77, 32'h0, 4'h1, 1'b0, 0, R_ERR, 32'h0, 1'b0);

        dwb_adr = 30'h2A; dwb_sel = 4'hF; dwb_wre = 1'b0; dwb_stb = 1'b1;
        tick();
        chk("busy_before_rst", wb_cyc_o, 1'b1);
        sys_rst = 1'b1;
        dwb_stb = 1'b0;
        tick();
        sys_rst = 1'b0;
        m_berr = 1'b0;
        m_badr = '0;
        chk("rst_mid_busy",
            {dwb_dti, dwb_ack, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, berr, berr_adr},
            133'd0);
        repeat (4) tick();
        chk("no_ack_after_rst", acks, acks_exp);

        access(30'h5, 32'h0, 4'hF, 1'b0, 1, R_ACK, 32'h0BAD_F00D, 1'b0);
        tick();

        chk("queue_empty", q.size(), 0);
        chk("ack_count", acks, acks_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
